// File: rtl/cook_timer_ctrl.sv
// Cook timer controller for the microwave oven.
// Holds the programmed/remaining cook time, generates the one-second tick
// while cooking, and runs the end-of-cook buzzer sequence.
//
// End sequencer states:
//   state  | meaning
//   E_IDLE | not in COOK_END, or waiting for the COOK_END entry edge
//   E_BUZZ | buzzer sounding, counting END_SEC seconds or waiting for C
//   E_DONE | end_event issued, waiting for oven to leave COOK_END
module cook_timer_ctrl #(
    parameter int TICK_DIV = 100000000,
    parameter int STEP_SEC = 30,
    parameter int MAX_TIME = 5999,
    parameter int END_SEC  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  oven_state,
    input  logic [4:0]  rise_button,
    output logic [13:0] set_time,
    output logic        sec_tick,
    output logic        buzzer,
    output logic        end_event
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (END_SEC > 0) ? $clog2(END_SEC + 1) : 1;

    localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] END_TC   = SW'(END_SEC - 1);
    localparam logic [14:0]   STEP15   = 15'(STEP_SEC);
    localparam logic [14:0]   MAX15    = 15'(MAX_TIME);

    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_READY = 3'b001;
    localparam logic [2:0] ST_COOK  = 3'b010;
    localparam logic [2:0] ST_PAUSE = 3'b011;
    localparam logic [2:0] ST_END   = 3'b100;

    typedef enum logic [1:0] {
        E_IDLE = 2'b00,
        E_BUZZ = 2'b01,
        E_DONE = 2'b10
    } end_state_t;

    logic [PW-1:0] r_presc;
    logic [2:0]    r_prev_state;
    logic [SW-1:0] r_end_sec;
    end_state_t    r_end_state;

    end_state_t    w_end_next;
    logic          w_sec_clr;
    logic          w_sec_inc;
    logic          w_in_cook;
    logic          w_in_end;
    logic          w_in_setup;
    logic          w_end_entry;
    logic          w_idle_entry;
    logic          w_counting;
    logic          w_wrap;
    logic          w_btn_u;
    logic          w_btn_c;
    logic          w_btn_d;
    logic [14:0]   w_sum;
    logic [14:0]   w_diff;
    logic [13:0]   w_time_next;

    assign w_btn_u = rise_button[0];
    assign w_btn_c = rise_button[1];
    assign w_btn_d = rise_button[4];

    assign w_in_cook    = (oven_state == ST_COOK);
    assign w_in_end     = (oven_state == ST_END);
    assign w_in_setup   = (oven_state == ST_IDLE) || (oven_state == ST_READY);
    assign w_end_entry  = w_in_end && (r_prev_state != ST_END);
    assign w_idle_entry = (oven_state == ST_IDLE) &&
                          ((r_prev_state == ST_COOK) || (r_prev_state == ST_PAUSE) ||
                           (r_prev_state == ST_END));
    // The COOK_END entry cycle restarts the prescaler instead of counting.
    assign w_counting   = w_in_cook || (w_in_end && !w_end_entry);
    assign w_wrap       = w_counting && (r_presc == PRESC_TC);

    // 15-bit so the +STEP / -STEP results can be saturated without wrapping.
    assign w_sum  = {1'b0, set_time} + STEP15;
    assign w_diff = {1'b0, set_time} - STEP15;

    // Next cook time: door/idle edits, per-second countdown, clear on abort.
    always_comb begin
        w_time_next = set_time;
        if (w_idle_entry) begin
            w_time_next = '0;
        end else if (w_in_setup) begin
            if (w_btn_c) begin
                w_time_next = '0;
            end else if (w_btn_u && !w_btn_d) begin
                w_time_next = (w_sum > MAX15) ? MAX15[13:0] : w_sum[13:0];
            end else if (w_btn_d && !w_btn_u) begin
                w_time_next = ({1'b0, set_time} < STEP15) ? 14'd0 : w_diff[13:0];
            end
        end else if (w_in_cook && w_wrap && (set_time != 14'd0)) begin
            w_time_next = set_time - 14'd1;
        end
    end

    // Prescaler, previous-state register, cook time and second tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc      <= '0;
            r_prev_state <= ST_IDLE;
            set_time     <= '0;
            sec_tick     <= 1'b0;
        end else begin
            r_prev_state <= oven_state;
            set_time     <= w_time_next;
            sec_tick     <= w_in_cook && w_wrap;
            if (w_in_setup || w_end_entry) begin
                r_presc <= '0;
            end else if (w_counting) begin
                r_presc <= w_wrap ? '0 : r_presc + 1'b1;
            end
        end
    end

    // End sequencer next-state and second-counter control.
    always_comb begin
        w_end_next = r_end_state;
        w_sec_clr  = 1'b0;
        w_sec_inc  = 1'b0;
        if (!w_in_end) begin
            w_end_next = E_IDLE;
        end else begin
            case (r_end_state)
                E_IDLE: begin
                    if (w_end_entry) begin
                        w_end_next = E_BUZZ;
                        w_sec_clr  = 1'b1;
                    end
                end
                E_BUZZ: begin
                    if (w_btn_c || (w_wrap && (r_end_sec == END_TC))) begin
                        w_end_next = E_DONE;
                    end else if (w_wrap) begin
                        w_sec_inc = 1'b1;
                    end
                end
                E_DONE:  w_end_next = E_DONE;
                default: w_end_next = E_IDLE;
            endcase
        end
    end

    // End sequencer state, second counter and registered alarm outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_end_state <= E_IDLE;
            r_end_sec   <= '0;
            buzzer      <= 1'b0;
            end_event   <= 1'b0;
        end else begin
            r_end_state <= w_end_next;
            if (w_sec_clr) begin
                r_end_sec <= '0;
            end else if (w_sec_inc) begin
                r_end_sec <= r_end_sec + 1'b1;
            end
            buzzer    <= (w_end_next == E_BUZZ);
            end_event <= (r_end_state == E_BUZZ) && (w_end_next == E_DONE);
        end
    end

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Bench for cook_timer_ctrl: directed oven/button sequences, a cycle model
// compared every cycle, and literal checkpoints at the interesting moments.
module tb_cook_timer_ctrl;

    localparam int TD   = 4;
    localparam int STEP = 30;
    localparam int MAXT = 5999;
    localparam int ENDS = 2;

    localparam logic [2:0] IDLE = 3'd0, READY = 3'd1, COOK = 3'd2, PAUSE = 3'd3, CEND = 3'd4;
    localparam logic [4:0] BU = 5'b00001, BC = 5'b00010, BL = 5'b00100, BR = 5'b01000, BD = 5'b10000;

    logic        clk;
    logic        reset;
    logic [2:0]  oven_state;
    logic [4:0]  rise_button;
    logic [13:0] set_time;
    logic        sec_tick;
    logic        buzzer;
    logic        end_event;

    int n_checks = 0;
    int n_fail   = 0;

    cook_timer_ctrl #(
        .TICK_DIV(TD), .STEP_SEC(STEP), .MAX_TIME(MAXT), .END_SEC(ENDS)
    ) dut (
        .clk(clk), .reset(reset), .oven_state(oven_state), .rise_button(rise_button),
        .set_time(set_time), .sec_tick(sec_tick), .buzzer(buzzer), .end_event(end_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: time in seconds, phase within the current second,
    // and the COOK_END visit measured in elapsed cycles.
    int m_time, m_phase, m_prev, m_end_cyc;
    bit m_tick, m_buzz, m_evt, m_active;

    always @(posedge clk or negedge reset) begin : model
        int  st, nt;
        bit  entry, counting, wrap, u, c, d;
        if (!reset) begin
            m_time <= 0; m_phase <= 0; m_prev <= 0; m_end_cyc <= 0;
            m_tick <= 0; m_buzz <= 0; m_evt <= 0; m_active <= 0;
        end else begin
            st       = int'(oven_state);
            u        = rise_button[0];
            c        = rise_button[1];
            d        = rise_button[4];
            entry    = (st == 4) && (m_prev != 4);
            counting = (st == 2) || (st == 4 && !entry);
            wrap     = counting && (m_phase == TD - 1);
            nt       = m_time;
            if (st == 0 && (m_prev == 2 || m_prev == 3 || m_prev == 4)) nt = 0;
            else if (st <= 1) begin
                if (c) nt = 0;
                else if (u && !d) nt = (m_time + STEP > MAXT) ? MAXT : m_time + STEP;
                else if (d && !u) nt = (m_time - STEP < 0) ? 0 : m_time - STEP;
            end else if (st == 2 && wrap && m_time > 0) nt = m_time - 1;
            m_time <= nt;
            m_tick <= (st == 2) && wrap;
            if (st <= 1 || entry) m_phase <= 0;
            else if (counting)    m_phase <= (m_phase + 1) % TD;
            if (st != 4) begin
                m_buzz <= 0; m_evt <= 0; m_active <= 0;
            end else if (entry) begin
                m_buzz <= 1; m_evt <= 0; m_active <= 1; m_end_cyc <= 0;
            end else if (m_active) begin
                m_end_cyc <= m_end_cyc + 1;
                if (c || (m_end_cyc + 1 == ENDS * TD)) begin
                    m_evt <= 1; m_buzz <= 0; m_active <= 0;
                end else m_evt <= 0;
            end else m_evt <= 0;
            m_prev <= st;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("mdl_set_time", int'(set_time), m_time);
        chk("mdl_sec_tick", int'(sec_tick), int'(m_tick));
        chk("mdl_buzzer", int'(buzzer), int'(m_buzz));
        chk("mdl_end_event", int'(end_event), int'(m_evt));
    end

    task automatic step(input logic [2:0] st, input logic [4:0] b);
        oven_state  = st;
        rise_button = b;
        @(negedge clk);
        rise_button = 5'b0;
    endtask

    task automatic hold(input logic [2:0] st, input int n);
        for (int i = 0; i < n; i++) step(st, 5'b0);
    endtask

    initial begin
        reset       = 1'b0;
        oven_state  = IDLE;
        rise_button = 5'b0;
        repeat (2) @(negedge clk);
        chk("rst_set_time", int'(set_time), 0);
        chk("rst_buzzer", int'(buzzer), 0);
        reset = 1'b1;

        // Button edits in IDLE, including saturation at 0 and U+D cancel.
        for (int i = 0; i < 3; i++) step(IDLE, BU);
        chk("u3_90", int'(set_time), 90);
        for (int i = 0; i < 4; i++) step(IDLE, BD);
        chk("d4_sat0", int'(set_time), 0);
        step(IDLE, BU);
        step(IDLE, BU | BD);
        chk("ud_hold", int'(set_time), 30);
        step(IDLE, BL | BR);
        chk("lr_ignored", int'(set_time), 30);
        step(IDLE, BC | BD);
        chk("c_prio", int'(set_time), 0);

        // Upper saturation.
        for (int i = 0; i < 199; i++) step(IDLE, BU);
        chk("u199", int'(set_time), 5970);
        step(IDLE, BU);
        chk("sat_max", int'(set_time), 5999);
        step(READY, BU);
        chk("sat_max2", int'(set_time), 5999);
        step(READY, BD);
        chk("d_from_max", int'(set_time), 5969);
        step(READY, BU | BC);
        chk("uc_clear", int'(set_time), 0);

        // Countdown from 30 s; READY->IDLE keeps the time.
        step(READY, BU);
        step(IDLE, 5'b0);
        chk("door_keep", int'(set_time), 30);
        step(READY, 5'b0);
        hold(COOK, 3);
        chk("cook_c3", int'(set_time), 30);
        step(COOK, BU | BC);
        chk("cook_c4", int'(set_time), 29);
        chk("tick_c4", int'(sec_tick), 1);
        step(COOK, 5'b0);
        chk("tick_c5", int'(sec_tick), 0);
        hold(COOK, 3);
        chk("cook_c8", int'(set_time), 28);
        hold(COOK, 112);
        chk("cook_c120", int'(set_time), 0);
        hold(COOK, 10);
        chk("cook_hold0", int'(set_time), 0);

        // Pause with prescaler at 2, resume, then abort to IDLE.
        step(IDLE, 5'b0);
        step(IDLE, BU);
        step(IDLE, BU);
        step(READY, 5'b0);
        hold(COOK, 6);
        chk("pre_pause", int'(set_time), 59);
        step(PAUSE, BU);
        hold(PAUSE, 9);
        chk("pause_hold", int'(set_time), 59);
        step(COOK, 5'b0);
        chk("resume_c1", int'(set_time), 59);
        step(COOK, 5'b0);
        chk("resume_c2", int'(set_time), 58);
        step(PAUSE, 5'b0);
        step(IDLE, 5'b0);
        chk("abort_clear", int'(set_time), 0);

        // COOK_END: full buzzer time, then early stop by C.
        step(READY, 5'b0);
        hold(COOK, 2);
        step(CEND, 5'b0);
        chk("buzz_c1", int'(buzzer), 1);
        hold(CEND, 7);
        chk("buzz_c8", int'(buzzer), 1);
        chk("evt_c8", int'(end_event), 0);
        step(CEND, 5'b0);
        chk("evt_c9", int'(end_event), 1);
        chk("buzz_c9", int'(buzzer), 0);
        step(CEND, 5'b0);
        chk("evt_c10", int'(end_event), 0);
        step(CEND, BC);
        hold(CEND, 10);
        chk("evt_once", int'(end_event), 0);
        step(IDLE, 5'b0);
        chk("end_clear", int'(set_time), 0);
        step(READY, 5'b0);
        step(COOK, 5'b0);
        step(CEND, 5'b0);
        step(CEND, 5'b0);
        step(CEND, BC);
        chk("c_evt_c4", int'(end_event), 1);
        step(CEND, 5'b0);
        chk("c_evt_c5", int'(end_event), 0);
        step(IDLE, 5'b0);
        step(READY, 5'b0);
        hold(CEND, 3);
        step(IDLE, 5'b0);
        chk("leave_buzz", int'(buzzer), 0);

        // Asynchronous reset mid-cook.
        step(IDLE, BU);
        step(IDLE, BU);
        step(READY, 5'b0);
        hold(COOK, 5);
        chk("pre_rst", int'(set_time), 59);
        #1 reset = 1'b0;
        #1;
        chk("arst_set_time", int'(set_time), 0);
        chk("arst_sec_tick", int'(sec_tick), 0);
        chk("arst_buzzer", int'(buzzer), 0);
        chk("arst_end_event", int'(end_event), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        hold(COOK, 3);
        chk("post_rst_c3", int'(sec_tick), 0);
        step(COOK, 5'b0);
        chk("post_rst_tick", int'(sec_tick), 1);
        hold(COOK, 10);
        chk("post_rst_time", int'(set_time), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
